// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU controller slice.
//   - opcode constants driven to the downstream ALU
//   - FSM state type
//   - instruction field positions and a decoded-instruction struct
package alu_pkg;

    // Instruction field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RA_HI  = 9;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 7;
    localparam int RB_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Opcodes
    localparam logic [3:0] PASS_A = 4'h0;
    localparam logic [3:0] PASS_B = 4'h1;
    localparam logic [3:0] ADD    = 4'h2;
    localparam logic [3:0] NEG    = 4'h3;
    localparam logic [3:0] AND    = 4'h4;
    localparam logic [3:0] OR     = 4'h5;
    localparam logic [3:0] SHL    = 4'h6;
    localparam logic [3:0] SHR    = 4'h7;
    localparam logic [3:0] EQ     = 4'h8;
    localparam logic [3:0] GT     = 4'h9;
    localparam logic [3:0] SETC   = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;   // overlaps rb; meaningful only for SETC
    } instr_t;

    function automatic instr_t decode(input logic [15:0] w);
        instr_t d;
        d.op  = w[OPC_HI:OPC_LO];
        d.rd  = w[RD_HI:RD_LO];
        d.ra  = w[RA_HI:RA_LO];
        d.rb  = w[RB_HI:RB_LO];
        d.imm = w[IMM_HI:IMM_LO];
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4 x 8-bit register file.
//   clk, rst_n          : clock, async active-low reset (all entries -> RST_VAL)
//   we, waddr, wdata    : synchronous write port
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
module alu_regfile #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b
);

    logic [3:0][7:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mem <= {4{RST_VAL}};
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: multi-cycle controller feeding an external combinational ALU.
//   One instruction per 4 cycles: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
//   clk, rst_n           : clock, async active-low reset
//   instr_valid, instr   : instruction input, accepted when instr_ready
//   instr_ready          : high only in IDLE
//   alu_op, alu_a, alu_b : operands to the ALU, held outside EXECUTE
//   alu_z                : combinational ALU result
//   done, result         : writeback pulse and last written-back value
//   zero_flag            : only when ALU_CTRL_FLAGS_EN is defined
module alu_ctrl
    import alu_pkg::*;
#(
    parameter logic [7:0] REG_RST_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_z,
    output logic        done,
    output logic [7:0]  result
`ifdef ALU_CTRL_FLAGS_EN
    ,
    output logic        zero_flag
`endif
);

    state_t     state;
    instr_t     ir;
    logic [7:0] rd_a, rd_b;

    // result doubles as the capture register for alu_z: it is loaded at the
    // end of EXECUTE so it is already valid while done is high in WRITEBACK,
    // and the register-file write lands at the end of WRITEBACK.
    alu_regfile #(.RST_VAL(REG_RST_VAL)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (state == WRITEBACK),
        .waddr   (ir.rd),
        .wdata   (result),
        .raddr_a (ir.ra),
        .raddr_b (ir.rb),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir        <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            result    <= '0;
            done      <= 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
            zero_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= decode(instr);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    // operands sampled here, before any write to rd
                    alu_op <= ir.op;
                    alu_a  <= rd_a;
                    alu_b  <= (ir.op == SETC) ? ir.imm : rd_b;
                    state  <= EXECUTE;
                end
                EXECUTE: begin
                    result    <= alu_z;
                    done      <= 1'b1;
`ifdef ALU_CTRL_FLAGS_EN
                    zero_flag <= (alu_z == 8'h00);
`endif
                    state     <= WRITEBACK;
                end
                WRITEBACK: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam logic [7:0] RST_V = 8'h3C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_z;
    logic        done;
    logic [7:0]  result;
`ifdef ALU_CTRL_FLAGS_EN
    logic        zero_flag;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic [7:0] mreg[4];
    int done_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl #(.REG_RST_VAL(RST_V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_z       (alu_z),
        .done        (done),
        .result      (result)
`ifdef ALU_CTRL_FLAGS_EN
        ,
        .zero_flag   (zero_flag)
`endif
    );

    // Reference ALU: drives alu_z and computes scoreboard expectations.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            PASS_A:  alu_f = a;
            PASS_B:  alu_f = b;
            ADD:     alu_f = 8'(a + b);
            NEG:     alu_f = 8'(8'h00 - a);
            AND:     alu_f = a & b;
            OR:      alu_f = a | b;
            SHL:     alu_f = {a[6:0], 1'b0};
            SHR:     alu_f = {1'b0, a[7:1]};
            EQ:      alu_f = {7'b0, a == b};
            GT:      alu_f = {7'b0, a > b};
            SETC:    alu_f = b;
            default: alu_f = 8'h00;
        endcase
    endfunction

    assign alu_z = alu_f(alu_op, alu_a, alu_b);

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 6'b0};
    endfunction

    function automatic logic [15:0] mk_setc(input logic [1:0] rd, input logic [7:0] imm);
        return {SETC, rd, 2'b00, imm};
    endfunction

    // Push expected writeback value and update the register model.
    task automatic push_model(input logic [15:0] w);
        logic [3:0] op;
        logic [7:0] b, e;
        op = w[15:12];
        b  = (op == SETC) ? w[7:0] : mreg[w[7:6]];
        e  = alu_f(op, mreg[w[9:8]], b);
        sb.push_back(e);
        mreg[w[11:10]] = e;
    endtask

    // Issue one instruction from a negedge; returns cycles from acceptance to
    // done (10 = never) and leaves the bench at the negedge of the IDLE cycle.
    task automatic exec(input logic [15:0] w, output int lat);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        instr = w;
        instr_valid = 1'b1;
        push_model(w);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done result=%h (no writeback expected)", result);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL sb_result got=%h exp=%h", result, e);
                end
`ifdef ALU_CTRL_FLAGS_EN
                checks++;
                if (zero_flag !== (e == 8'h00)) begin
                    errors++;
                    $display("FAIL sb_zero_flag got=%b exp=%b", zero_flag, (e == 8'h00));
                end
`endif
            end
        end
    end

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        if (done !== 1'b0)        begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        if (result !== 8'h00)     begin errors++; $display("FAIL rst_result got=%h exp=00", result); end
        if (alu_op !== 4'h0)      begin errors++; $display("FAIL rst_alu_op got=%h exp=0", alu_op); end
        if (alu_a !== 8'h00)      begin errors++; $display("FAIL rst_alu_a got=%h exp=00", alu_a); end
        if (alu_b !== 8'h00)      begin errors++; $display("FAIL rst_alu_b got=%h exp=00", alu_b); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", instr_ready); end
        for (int i = 0; i < 4; i++) mreg[i] = RST_V;
        for (int i = 0; i < 4; i++) exec(mk(PASS_A, 2'(i), 2'(i), 2'(0)), lat);
    endtask

    task automatic test_setc();
        int lat;
        instr = mk_setc(2'd1, 8'h05);
        instr_valid = 1'b1;
        push_model(instr);
        @(negedge clk);               // cycle 1: DECODE
        instr_valid = 1'b0;
        checks += 2;
        if (instr_ready !== 1'b0) begin errors++; $display("FAIL setc_ready_decode got=%b exp=0", instr_ready); end
        if (done !== 1'b0)        begin errors++; $display("FAIL setc_done_c1 got=%b exp=0", done); end
        @(negedge clk);               // cycle 2: EXECUTE
        checks += 3;
        if (alu_op !== SETC)      begin errors++; $display("FAIL setc_alu_op got=%h exp=%h", alu_op, SETC); end
        if (alu_b !== 8'h05)      begin errors++; $display("FAIL setc_alu_b got=%h exp=05", alu_b); end
        if (done !== 1'b0)        begin errors++; $display("FAIL setc_done_c2 got=%b exp=0", done); end
        @(negedge clk);               // cycle 3: WRITEBACK
        checks += 2;
        if (done !== 1'b1)        begin errors++; $display("FAIL setc_done_c3 got=%b exp=1", done); end
        if (result !== 8'h05)     begin errors++; $display("FAIL setc_result got=%h exp=05", result); end
        @(negedge clk);               // cycle 4: IDLE
        checks += 3;
        if (done !== 1'b0)        begin errors++; $display("FAIL setc_done_c4 got=%b exp=0", done); end
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL setc_ready_c4 got=%b exp=1", instr_ready); end
        if (result !== 8'h05)     begin errors++; $display("FAIL setc_result_hold got=%h exp=05", result); end
        exec(mk(PASS_A, 2'd1, 2'd1, 2'd0), lat);
        checks++;
        if (result !== 8'h05)     begin errors++; $display("FAIL setc_reg1 got=%h exp=05", result); end
    endtask

    task automatic test_wrap();
        int lat;
        exec(mk_setc(2'd2, 8'hFC), lat);
        exec(mk(ADD, 2'd3, 2'd1, 2'd2), lat);
        checks += 2;
        if (lat != 3)          begin errors++; $display("FAIL wrap_latency got=%0d exp=3", lat); end
        if (result !== 8'h01)  begin errors++; $display("FAIL wrap_result got=%h exp=01", result); end
    endtask

    task automatic test_rd_is_src();
        int lat;
        exec(mk_setc(2'd1, 8'h40), lat);
        exec(mk(ADD, 2'd1, 2'd1, 2'd1), lat);
        checks++;
        if (result !== 8'h80) begin errors++; $display("FAIL rdsrc_result got=%h exp=80", result); end
        exec(mk(PASS_A, 2'd1, 2'd1, 2'd0), lat);
        checks++;
        if (result !== 8'h80) begin errors++; $display("FAIL rdsrc_reg1 got=%h exp=80", result); end
    endtask

    task automatic test_ops();
        int lat;
        for (int op = 0; op < 16; op++) begin
            exec(mk_setc(2'd1, 8'($urandom_range(0, 255))), lat);
            exec(mk_setc(2'd2, 8'($urandom_range(0, 255))), lat);
            exec(mk(4'(op), 2'd0, 2'd1, 2'd2), lat);
            checks++;
            if (lat != 3) begin errors++; $display("FAIL ops_latency op=%0d got=%0d exp=3", op, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int d0;
        exec(mk_setc(2'd3, 8'h07), lat);
        d0 = done_cnt;
        instr = mk(ADD, 2'd0, 2'd0, 2'd3);
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            checks += 2;
            if (instr_ready !== (c % 4 == 0)) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, instr_ready, (c % 4 == 0)); end
            if (done !== (c % 4 == 3))        begin errors++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, (c % 4 == 3)); end
            if (instr_ready) push_model(instr);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++;
        if (done_cnt - d0 != 4) begin errors++; $display("FAIL b2b_done_count got=%0d exp=4", done_cnt - d0); end
    endtask

    task automatic test_reset_exec();
        int lat;
        int d0;
        exec(mk_setc(2'd0, 8'h99), lat);
        instr = mk_setc(2'd2, 8'h77);   // discarded: not pushed, model untouched
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);                 // now in EXECUTE
        #2 rst_n = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        checks += 4;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rstx_idle got=%b exp=1", instr_ready); end
        if (done !== 1'b0)        begin errors++; $display("FAIL rstx_done got=%b exp=0", done); end
        if (result !== 8'h00)     begin errors++; $display("FAIL rstx_result got=%h exp=00", result); end
        if (alu_op !== 4'h0)      begin errors++; $display("FAIL rstx_alu_op got=%h exp=0", alu_op); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL rstx_no_done got=%0d exp=0", done_cnt - d0); end
        for (int i = 0; i < 4; i++) mreg[i] = RST_V;
        for (int i = 0; i < 4; i++) exec(mk(PASS_A, 2'(i), 2'(i), 2'(0)), lat);
    endtask

`ifdef ALU_CTRL_FLAGS_EN
    task automatic test_flags();
        int lat;
        exec(mk_setc(2'd1, 8'h11), lat);
        checks++;
        if (zero_flag !== 1'b0) begin errors++; $display("FAIL flag_nonzero got=%b exp=0", zero_flag); end
        exec(mk_setc(2'd2, 8'h22), lat);
        exec(mk(EQ, 2'd0, 2'd1, 2'd2), lat);
        checks += 2;
        if (result !== 8'h00)   begin errors++; $display("FAIL flag_eq_result got=%h exp=00", result); end
        if (zero_flag !== 1'b1) begin errors++; $display("FAIL flag_zero got=%b exp=1", zero_flag); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_setc();
        test_wrap();
        test_rd_is_src();
        test_ops();
        test_back_to_back();
        test_reset_exec();
`ifdef ALU_CTRL_FLAGS_EN
        test_flags();
`endif
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: REG_RST_VAL, default 8'h00, reset value loaded into every register-file entry.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 instr_valid  input  1  instruction word on instr is valid.
REQ-005 instr  input  16  instruction: [15:12] opcode, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm (opcode 4'b1111 only).
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 alu_op  output  4  opcode driven to the downstream ALU.
REQ-008 alu_a  output  8  operand A to the ALU.
REQ-009 alu_b  output  8  operand B to the ALU.
REQ-010 alu_z  input  8  combinational result returned by the ALU.
REQ-011 done  output  1  one-cycle pulse when a result is written back.
REQ-012 result  output  8  last written-back value; held until the next writeback.

Function
REQ-013 The block SHALL hold a 4-entry x 8-bit register file, indexed by 2-bit fields.
REQ-014 The FSM SHALL have states IDLE, DECODE, EXECUTE, WRITEBACK, traversed strictly in that order and then back to IDLE.
REQ-015 instr_ready SHALL be 1 only in IDLE.
- Handshake: an instruction is accepted when instr_valid && instr_ready at a rising edge.
- On acceptance, instr is latched and the FSM moves to DECODE.
REQ-016 In IDLE with instr_valid=0, the FSM SHALL stay in IDLE and leave all registers unchanged.
REQ-017 In DECODE, operand registers SHALL be loaded:
- opA = reg[ra].
- opB = imm when opcode==4'b1111, else reg[rb].
REQ-018 In EXECUTE, alu_op/alu_a/alu_b SHALL present latched opcode/opA/opB, and alu_z SHALL be captured into a result register at the end of the cycle.
REQ-019 Outside EXECUTE, alu_op/alu_a/alu_b SHALL hold their last values; they are don't-care to the ALU.
REQ-020 In WRITEBACK, the block SHALL:
- write the captured value to reg[rd];
- update result;
- assert done for exactly one cycle.
REQ-021 Latency SHALL be fixed: acceptance edge N -> done high during cycle N+3; next acceptance no earlier than edge N+4.
REQ-022 Throughput SHALL be one instruction per 4 cycles.
REQ-023 Read-after-write SHALL be correct: an instruction accepted after done observes the written value, because DECODE follows WRITEBACK.
REQ-024 rd equal to ra or rb SHALL be legal; operands are sampled in DECODE, before the write.
REQ-025 All data paths SHALL be 8-bit, and overflow SHALL wrap modulo 256 (handled by the ALU).
REQ-026 Undefined opcodes SHALL be passed through unchanged, and the ALU's output (zero) SHALL be written back normally.

Reset
REQ-027 While rst_n=0, regardless of clk or an in-flight instruction, the block SHALL force:
- FSM = IDLE;
- all register entries = REG_RST_VAL;
- alu_op/alu_a/alu_b = 0;
- result = 0;
- done = 0.
REQ-028 An instruction in progress when reset asserts SHALL be discarded, with no writeback.
REQ-029 instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 With ALU_CTRL_FLAGS_EN defined, the block SHALL add output zero_flag (1 bit):
- updated in WRITEBACK to (written value == 0);
- reset to 0;
- held otherwise.
REQ-031 Without ALU_CTRL_FLAGS_EN, the zero_flag port and its logic SHALL not exist.

Structure
REQ-032 Shared package alu_pkg SHALL contain:
- opcode constants (PASS_A, PASS_B, ADD, NEG, AND, OR, SHL, SHR, EQ, GT, SETC=4'b1111);
- the FSM state type;
- instruction field-position constants.
REQ-033 The register file SHALL be a sub-module alu_regfile: two combinational read ports, one synchronous write port, async active-low reset.

Verification
REQ-034 Reset, then SETC rd=1 imm=8'h05 -> done in cycle 3 after acceptance, result=8'h05, reg1=8'h05.
REQ-035 reg1=5, SETC rd=2 imm=8'hFC, then ADD rd=3 ra=1 rb=2 -> result=8'h01 (wrap).
REQ-036 Hold instr_valid=1 continuously -> instr_ready low for 3 cycles after each acceptance, one done per 4 cycles.
REQ-037 ADD rd=1 ra=1 rb=1 with reg1=8'h40 -> result=8'h80, reg1=8'h80.
REQ-038 Assert rst_n=0 in EXECUTE -> no done, all registers = REG_RST_VAL, FSM IDLE.
REQ-039 With ALU_CTRL_FLAGS_EN: EQ rd=0 on unequal operands -> result=0, zero_flag=1.
